// File: rtl/otter_fetch_ctrl.sv
// Instruction fetch controller for the OTTER core: sequences PC loads and
// instruction-memory requests, handles stalls, branch/trap redirects and draining.
module otter_fetch_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
   input  logic        FC_CLK,
   input  logic        FC_RST,
   input  logic [31:0] FC_PC,
   output logic        FC_PC_LD,
   output logic [31:0] FC_PC_DIN,
   output logic        FC_IMEM_REQ,
   output logic [31:0] FC_IMEM_ADDR,
   input  logic        FC_IMEM_ACK,
   input  logic        FC_STALL,
   input  logic        FC_BR_TAKEN,
   input  logic [31:0] FC_BR_TGT,
   input  logic        FC_TRAP,
   input  logic [31:0] FC_TRAP_VEC,
   output logic        FC_IF_VALID,
   output logic        FC_FLUSH,
   output logic [31:0] FC_FETCH_CNT
);

   typedef enum logic [2:0] {StBoot, StReq, StWait, StHold, StDrain} state_e;

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic        redir;
   logic [31:0] redir_tgt;
   logic [31:0] pc_inc;

   assign redir     = FC_TRAP | FC_BR_TAKEN;
   assign redir_tgt = (FC_TRAP ? FC_TRAP_VEC : FC_BR_TGT) & 32'hFFFF_FFFC;
   assign pc_inc    = FC_PC + 32'd4;

   always_ff @(posedge FC_CLK or posedge FC_RST) begin
      if (FC_RST) begin
         state_q <= StBoot;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBoot:  state_d = StReq;
         StReq:   state_d = redir ? StReq : StWait;
         StWait: begin
            if (redir)            state_d = FC_IMEM_ACK ? StReq : StDrain;
            else if (FC_IMEM_ACK) state_d = FC_STALL ? StHold : StReq;
         end
         StHold: begin
            if (redir || !FC_STALL) state_d = StReq;
         end
         StDrain: begin
            if (FC_IMEM_ACK) state_d = StReq;
         end
         default: state_d = StBoot;
      endcase
   end

   // Outputs are forced low while reset is held, independent of the clock.
   always_comb begin
      FC_PC_LD    = 1'b0;
      FC_PC_DIN   = 32'd0;
      FC_IMEM_REQ = 1'b0;
      FC_IF_VALID = 1'b0;
      FC_FLUSH    = 1'b0;
      if (!FC_RST) begin
         if (state_q == StBoot) begin
            FC_PC_LD  = 1'b1;
            FC_PC_DIN = RESET_VEC;
         end else if (redir) begin
            FC_PC_LD  = 1'b1;
            FC_PC_DIN = redir_tgt;
            FC_FLUSH  = 1'b1;
         end else begin
            unique case (state_q)
               StReq: FC_IMEM_REQ = 1'b1;
               StWait: begin
                  if (FC_IMEM_ACK && !FC_STALL) begin
                     FC_IF_VALID = 1'b1;
                     FC_PC_LD    = 1'b1;
                     FC_PC_DIN   = pc_inc;
                  end
               end
               StHold: begin
                  if (!FC_STALL) begin
                     FC_IF_VALID = 1'b1;
                     FC_PC_LD    = 1'b1;
                     FC_PC_DIN   = pc_inc;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign cnt_d        = cnt_q + {31'd0, FC_IF_VALID};
   assign FC_IMEM_ADDR = FC_PC;
   assign FC_FETCH_CNT = cnt_q;

endmodule

// File: tb/tb_otter_fetch_ctrl.sv
// Self-checking bench for otter_fetch_ctrl: directed scenarios plus randomized
// traffic checked against a transaction-level model (outstanding/held/killed flags).
module tb_otter_fetch_ctrl;

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        pc_ld;
   logic [31:0] pc_din;
   logic        req;
   logic [31:0] addr;
   logic        ack, stall, br, trap;
   logic [31:0] btgt, tvec;
   logic        valid, flush;
   logic [31:0] cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: what is in flight, not which FSM state holds it.
   bit          m_boot, m_out, m_kill, m_held;
   bit          n_out, n_kill, n_held;
   logic [31:0] m_cnt, n_cnt;
   logic        exp_req, exp_valid, exp_flush, exp_ld;
   logic [31:0] exp_din;
   logic        ld_s, req_s;
   logic [31:0] din_s;

   otter_fetch_ctrl #(.RESET_VEC(RV)) dut (
      .FC_CLK(clk), .FC_RST(rst), .FC_PC(pc), .FC_PC_LD(pc_ld), .FC_PC_DIN(pc_din),
      .FC_IMEM_REQ(req), .FC_IMEM_ADDR(addr), .FC_IMEM_ACK(ack), .FC_STALL(stall),
      .FC_BR_TAKEN(br), .FC_BR_TGT(btgt), .FC_TRAP(trap), .FC_TRAP_VEC(tvec),
      .FC_IF_VALID(valid), .FC_FLUSH(flush), .FC_FETCH_CNT(cnt)
   );

   always #5 clk = ~clk;

   task automatic model_eval();
      logic [31:0] t;
      exp_req = 0; exp_valid = 0; exp_flush = 0; exp_ld = 0; exp_din = 32'd0;
      n_out = m_out; n_kill = m_kill; n_held = m_held;
      t = trap ? tvec : btgt;
      if (m_boot) begin
         exp_ld = 1; exp_din = RV;
      end else if (trap || br) begin
         exp_ld = 1; exp_din = {t[31:2], 2'b00}; exp_flush = 1; n_held = 0;
         if (m_out) begin
            if (ack) begin n_out = 0; n_kill = 0; end
            else n_kill = 1;
         end
      end else if (m_held) begin
         if (!stall) begin exp_valid = 1; exp_ld = 1; exp_din = pc + 32'd4; n_held = 0; end
      end else if (m_out) begin
         if (ack) begin
            n_out = 0;
            if (m_kill) n_kill = 0;
            else if (!stall) begin exp_valid = 1; exp_ld = 1; exp_din = pc + 32'd4; end
            else n_held = 1;
         end
      end else begin
         exp_req = 1; n_out = 1;
      end
      n_cnt = m_cnt + (exp_valid ? 32'd1 : 32'd0);
   endtask

   task automatic model_reset();
      m_boot = 1; m_out = 0; m_kill = 0; m_held = 0; m_cnt = 32'd0;
   endtask

   // Drive inputs just after an edge, then let combinational outputs settle.
   task automatic drive(input logic s, input logic b, input logic [31:0] bt,
                        input logic tp, input logic [31:0] tv, input logic a);
      stall = s; br = b; btgt = bt; trap = tp; tvec = tv; ack = a;
      #1;
      model_eval();
      ld_s = pc_ld; din_s = pc_din; req_s = req;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      m_boot = 0; m_out = n_out; m_kill = n_kill; m_held = n_held; m_cnt = n_cnt;
      if (ld_s) pc = din_s;
   endtask

   task automatic test_reset();
      rst = 0; pc = 32'd0; ack = 0; stall = 0; br = 0; trap = 0; btgt = 0; tvec = 0;
      #1 rst = 1;
      #1;
      if ({req, valid, flush, pc_ld} !== 4'b0000) begin n_err++;
         $display("FAIL reset_outs got %b exp 0000", {req, valid, flush, pc_ld}); end
      n_cmp++;
      if (cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %h exp 0", cnt); end
      n_cmp++;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      model_reset();
   endtask

   task automatic test_boot();
      drive(0, 0, 0, 0, 0, 0);
      if (pc_ld !== 1'b1 || pc_din !== 32'h100) begin n_err++;
         $display("FAIL boot_load got %b/%h exp 1/00000100", pc_ld, pc_din); end
      n_cmp++;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         if (req !== 1'b1 || addr !== 32'h100 + 32'(4 * i)) begin n_err++;
            $display("FAIL boot_req%0d got %b/%h exp 1/%h", i, req, addr, 32'h100 + 32'(4 * i)); end
         n_cmp++;
         tick();
         drive(0, 0, 0, 0, 0, 1);
         if (valid !== 1'b1 || pc_din !== 32'h104 + 32'(4 * i)) begin n_err++;
            $display("FAIL boot_ack%0d got %b/%h exp 1/%h", i, valid, pc_din, 32'h104 + 32'(4 * i)); end
         n_cmp++;
         tick();
      end
      if (cnt !== 32'd3) begin n_err++; $display("FAIL boot_cnt got %0d exp 3", cnt); end
      n_cmp++;
   endtask

   task automatic test_stall();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, i == 0);
         if (valid !== 1'b0 || pc_ld !== 1'b0) begin n_err++;
            $display("FAIL stall_hold%0d got valid %b ld %b exp 0 0", i, valid, pc_ld); end
         n_cmp++;
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      if (valid !== 1'b1 || pc_din !== 32'h110) begin n_err++;
         $display("FAIL stall_release got %b/%h exp 1/00000110", valid, pc_din); end
      n_cmp++;
      tick();
      if (cnt !== 32'd4 || pc !== 32'h110) begin n_err++;
         $display("FAIL stall_after got cnt %0d pc %h exp 4 00000110", cnt, pc); end
      n_cmp++;
   endtask

   task automatic test_branch();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 1, 32'h203, 0, 0, 0);
      if (pc_ld !== 1'b1 || pc_din !== 32'h200 || flush !== 1'b1 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL br_redirect got ld %b din %h fl %b v %b exp 1 00000200 1 0",
                  pc_ld, pc_din, flush, valid);
      end
      n_cmp++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      if (req !== 1'b0 || valid !== 1'b0) begin n_err++;
         $display("FAIL br_drain got req %b v %b exp 0 0", req, valid); end
      n_cmp++;
      tick();
      drive(0, 0, 0, 0, 0, 1);
      if (req !== 1'b0 || valid !== 1'b0) begin n_err++;
         $display("FAIL br_late_ack got req %b v %b exp 0 0", req, valid); end
      n_cmp++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      if (req !== 1'b1 || addr !== 32'h200 || cnt !== 32'd4) begin n_err++;
         $display("FAIL br_refetch got %b/%h cnt %0d exp 1/00000200 4", req, addr, cnt); end
      n_cmp++;
      tick();
      drive(0, 0, 0, 0, 0, 1);
      if (valid !== 1'b1 || pc_din !== 32'h204) begin n_err++;
         $display("FAIL br_ack got %b/%h exp 1/00000204", valid, pc_din); end
      n_cmp++;
      tick();
   endtask

   task automatic test_trap();
      drive(0, 1, 32'h40, 1, 32'h80, 0);
      if (pc_din !== 32'h80 || flush !== 1'b1 || req !== 1'b0) begin n_err++;
         $display("FAIL trap_prio got din %h fl %b req %b exp 00000080 1 0", pc_din, flush, req); end
      n_cmp++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      if (req !== 1'b1 || addr !== 32'h80) begin n_err++;
         $display("FAIL trap_refetch got %b/%h exp 1/00000080", req, addr); end
      n_cmp++;
      tick();
      drive(0, 0, 0, 0, 0, 1);
      tick();
   endtask

   task automatic test_wrap();
      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      if (req !== 1'b1 || addr !== 32'hFFFF_FFFC) begin n_err++;
         $display("FAIL wrap_req got %b/%h exp 1/fffffffc", req, addr); end
      n_cmp++;
      tick();
      drive(0, 0, 0, 0, 0, 1);
      if (valid !== 1'b1 || pc_ld !== 1'b1 || pc_din !== 32'd0) begin n_err++;
         $display("FAIL wrap_din got %b/%b/%h exp 1/1/00000000", valid, pc_ld, pc_din); end
      n_cmp++;
      tick();
      if (cnt !== 32'd7) begin n_err++; $display("FAIL wrap_cnt got %0d exp 7", cnt); end
      n_cmp++;
   endtask

   task automatic test_async_reset();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      #2 rst = 1;
      #1;
      if ({req, valid, flush, pc_ld} !== 4'b0000 || cnt !== 32'd0) begin n_err++;
         $display("FAIL arst_outs got %b cnt %0d exp 0000 0", {req, valid, flush, pc_ld}, cnt); end
      n_cmp++;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 0;
      model_reset();
      drive(0, 0, 0, 0, 0, 1);
      if (pc_ld !== 1'b1 || pc_din !== RV || valid !== 1'b0 || req !== 1'b0) begin n_err++;
         $display("FAIL arst_boot got ld %b din %h v %b req %b exp 1 00000100 0 0",
                  pc_ld, pc_din, valid, req);
      end
      n_cmp++;
      tick();
      drive(0, 0, 0, 0, 0, 1);
      if (req !== 1'b1 || addr !== RV || valid !== 1'b0) begin n_err++;
         $display("FAIL arst_stale_ack got req %b addr %h v %b exp 1 00000100 0", req, addr, valid); end
      n_cmp++;
      tick();
      drive(0, 0, 0, 0, 0, 1);
      if (valid !== 1'b1 || pc_din !== 32'h104) begin n_err++;
         $display("FAIL arst_first got %b/%h exp 1/00000104", valid, pc_din); end
      n_cmp++;
      tick();
   endtask

   task automatic test_random();
      bit pend = 0;
      int lat = 0;
      logic s, b, tp, a;
      int r;
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(0, 9) < 3);
         r = $urandom_range(0, 99);
         b = (r < 8);
         tp = (r >= 95);
         a = pend && (lat == 0);
         drive(s, b, $urandom, tp, $urandom, a);
         if ({req, valid, flush, pc_ld} !== {exp_req, exp_valid, exp_flush, exp_ld}) begin
            n_err++;
            $display("FAIL rnd_ctl cyc %0d got %b exp %b", i, {req, valid, flush, pc_ld},
                     {exp_req, exp_valid, exp_flush, exp_ld});
         end
         n_cmp++;
         if (pc_din !== exp_din) begin n_err++;
            $display("FAIL rnd_din cyc %0d got %h exp %h", i, pc_din, exp_din); end
         n_cmp++;
         if (addr !== pc || cnt !== m_cnt) begin n_err++;
            $display("FAIL rnd_addr_cnt cyc %0d got %h/%0d exp %h/%0d", i, addr, cnt, pc, m_cnt); end
         n_cmp++;
         tick();
         if (a) pend = 0;
         else if (pend) lat--;
         if (req_s) begin pend = 1; lat = $urandom_range(0, 2); end
      end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_stall();
      test_branch();
      test_trap();
      test_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/otter_fetch_ctrl.md
OTTER_FETCH_CTRL -- requirements
Module: otter_fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 FC_CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 FC_RST  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 FC_PC  input  32  SHALL carry the current program-counter value.
REQ-005 FC_PC_LD  output  1  SHALL be the program-counter load enable.
REQ-006 FC_PC_DIN  output  32  SHALL be the program-counter next value.
REQ-007 FC_IMEM_REQ  output  1  SHALL be a one-cycle instruction-memory read request pulse.
REQ-008 FC_IMEM_ADDR  output  32  SHALL be the fetch address, equal to FC_PC.
REQ-009 FC_IMEM_ACK  input  1  SHALL indicate that read data is returned; earliest is 1 cycle after FC_IMEM_REQ.
REQ-010 FC_STALL  input  1  SHALL be the downstream IF/ID stall.
REQ-011 FC_BR_TAKEN / FC_BR_TGT  input  1/32  SHALL carry the branch/jump redirect and its target.
REQ-012 FC_TRAP / FC_TRAP_VEC  input  1/32  SHALL carry the trap/mret redirect and its target.
REQ-013 FC_IF_VALID  output  1  SHALL indicate that a valid instruction is presented to IF/ID this cycle.
REQ-014 FC_FLUSH  output  1  SHALL kill IF/ID contents this cycle.
REQ-015 FC_FETCH_CNT  output  32  SHALL count delivered instructions.

Function
REQ-016 The FSM SHALL have the states BOOT, REQ, WAIT, HOLD and DRAIN, with one-hot or binary encoding free.
REQ-017 Input priority SHALL be trap > branch > stall > sequential.
REQ-018 Redirect means FC_TRAP=1 or FC_BR_TAKEN=1; the redirect target is FC_TRAP_VEC if FC_TRAP=1, else FC_BR_TGT.
REQ-019 On any redirect outside BOOT, the block SHALL assert FC_PC_LD=1, FC_PC_DIN={target[31:2],2'b00}, FC_FLUSH=1 and FC_IF_VALID=0 in that cycle.
REQ-020 BOOT: FC_PC_LD=1, FC_PC_DIN=RESET_VEC, no request, redirects ignored; next state is REQ.
REQ-021 REQ, no redirect: FC_IMEM_REQ=1; next state is WAIT.
REQ-022 REQ, with redirect: FC_IMEM_REQ=0; next state is REQ, so the fetch is reissued at the new PC next cycle.
REQ-023 WAIT, no ACK, no redirect: stay in WAIT; FC_IMEM_REQ is not reasserted.
REQ-024 WAIT, ACK and FC_STALL=0: FC_IF_VALID=1, FC_PC_LD=1, FC_PC_DIN=FC_PC+4; next state is REQ.
REQ-025 WAIT, ACK and FC_STALL=1: the response is held and FC_IF_VALID=0; next state is HOLD.
REQ-026 WAIT, redirect with no ACK: next state is DRAIN.
REQ-027 WAIT, redirect with ACK in the same cycle: the response is discarded; next state is REQ.
REQ-028 HOLD, FC_STALL=1, no redirect: FC_IF_VALID=0 and no PC load; stay in HOLD.
REQ-029 HOLD, FC_STALL=0, no redirect: FC_IF_VALID=1 and PC loads FC_PC+4; next state is REQ.
REQ-030 HOLD, redirect: the held response is discarded; next state is REQ.
REQ-031 DRAIN: FC_IF_VALID=0 and no request; ACK is discarded; next state is REQ on ACK.
REQ-032 DRAIN, redirect: the PC is reloaded per REQ-019 and the state stays DRAIN unless ACK arrives in the same cycle.
REQ-033 A redirect SHALL override FC_STALL in every state.
REQ-034 FC_PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-035 FC_FETCH_CNT SHALL increment by 1 on each cycle with FC_IF_VALID=1 and wrap from 32'hFFFF_FFFF to 0.
REQ-036 At most one memory request SHALL be outstanding at any time.
REQ-037 An ACK seen in REQ, HOLD or BOOT SHALL be ignored, as a protocol violation.
REQ-038 Outputs not stated for a state SHALL be 0; FC_PC_DIN SHALL be 0 when FC_PC_LD=0.

Reset
REQ-039 While FC_RST=1, the state SHALL be BOOT, FC_FETCH_CNT SHALL be 0, and FC_IMEM_REQ, FC_IF_VALID, FC_FLUSH and FC_PC_LD SHALL be 0, independent of FC_CLK.
REQ-040 Reset asserted mid-operation, including in WAIT or DRAIN, SHALL abandon any outstanding request; the first cycle after deassertion SHALL be BOOT.

Verification
REQ-041 Boot test: reset release with RESET_VEC=32'h100 and ACK 1 cycle after each REQ -> FC_PC_DIN sequence 100, 104, 108; FC_IF_VALID pulses every 2 cycles; FC_FETCH_CNT=3 after 3 acks.
REQ-042 Stall test: FC_STALL=1 for 3 cycles at ACK -> state HOLD; FC_IF_VALID stays low for 3 cycles, then a single pulse; PC advances once; count increments once.
REQ-043 Branch test: branch to 32'h203 while in WAIT with ACK 2 cycles later -> FC_PC_DIN=32'h200 and FLUSH=1; the late ACK is discarded with no IF_VALID; the next REQ has address 32'h200.
REQ-044 Trap test: FC_TRAP=1 with FC_TRAP_VEC=32'h80 and FC_BR_TAKEN=1 with FC_BR_TGT=32'h40 in the same cycle -> FC_PC_DIN=32'h80.
REQ-045 Wrap test: FC_PC=32'hFFFF_FFFC with an ACK -> FC_PC_DIN=0; FC_FETCH_CNT preloaded near 32'hFFFF_FFFF via repeated fetches wraps to 0.
REQ-046 Reset test: FC_RST asserted asynchronously mid-WAIT -> outputs go to 0 before the next edge; after release, BOOT loads RESET_VEC and a stale ACK is ignored.
